// File: rtl/fdtd_field_probe.sv
// Ez field probe: captures Ez at one cell index once per decimated time step,
// tags it with the step number and queues it in a first-word fall-through FIFO.
module fdtd_field_probe #(
  parameter int FDTD_DATA_WIDTH = 32,
  parameter int IDX_WIDTH       = 16,
  parameter int STEP_WIDTH      = 16,
  parameter int FIFO_AW         = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       clken,
  input  logic                       probe_en,
  input  logic                       step_start,
  input  logic                       fld_valid,
  input  logic [IDX_WIDTH-1:0]       fld_idx,
  input  logic [FDTD_DATA_WIDTH-1:0] fld_ez,
  input  logic [IDX_WIDTH-1:0]       probe_idx,
  input  logic [7:0]                 decim,
  input  logic                       clr_ovf,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [FDTD_DATA_WIDTH-1:0] rd_ez,
  output logic [STEP_WIDTH-1:0]      rd_step,
  output logic [FIFO_AW:0]           fifo_level,
  output logic                       ovf
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int EW    = STEP_WIDTH + FDTD_DATA_WIDTH;

  logic [STEP_WIDTH-1:0]      step_cnt;
  logic [7:0]                 dcnt;
  logic                       armed;
  logic                       done;
  logic                       step_evt;
  logic                       armed_eff;
  logic                       done_eff;
  logic [STEP_WIDTH-1:0]      step_eff;
  logic                       match;

  logic                       st_valid;
  logic [STEP_WIDTH-1:0]      st_step;
  logic [FDTD_DATA_WIDTH-1:0] st_ez;

  logic [EW-1:0]              mem [DEPTH];
  logic [FIFO_AW-1:0]         wptr;
  logic [FIFO_AW-1:0]         rptr;
  logic [FIFO_AW:0]           level;
  logic [FIFO_AW-1:0]         head_sel;
  logic                       pop;
  logic                       push_ok;
  logic                       drop;

  // A sample arriving with step_start is judged against the new step's state.
  always_comb begin
    step_evt  = clken & probe_en & step_start;
    armed_eff = step_evt ? (dcnt == 8'd0) : armed;
    done_eff  = step_evt ? 1'b0 : done;
    step_eff  = step_evt ? (step_cnt + STEP_WIDTH'(1)) : step_cnt;
    match     = clken & probe_en & fld_valid & (fld_idx == probe_idx) & armed_eff & ~done_eff;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      step_cnt <= '0;
      dcnt     <= '0;
      armed    <= 1'b0;
      done     <= 1'b0;
    end else if (!probe_en) begin
      step_cnt <= '0;
      dcnt     <= '0;
      armed    <= 1'b0;
      done     <= 1'b0;
    end else if (clken) begin
      if (step_start) begin
        step_cnt <= step_eff;
        done     <= 1'b0;
        if (dcnt == 8'd0) begin
          armed <= 1'b1;
          dcnt  <= decim;
        end else begin
          armed <= 1'b0;
          dcnt  <= dcnt - 8'd1;
        end
      end
      if (match) done <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_valid <= 1'b0;
      st_step  <= '0;
      st_ez    <= '0;
    end else begin
      st_valid <= match;
      if (match) begin
        st_step <= step_eff;
        st_ez   <= fld_ez;
      end
    end
  end

  // level <= DEPTH always, so the MSB alone marks a full FIFO.
  always_comb begin
    pop      = (level != '0) & rd_ready;
    push_ok  = st_valid & (~level[FIFO_AW] | pop);
    drop     = st_valid & ~push_ok;
    head_sel = (level == '0) ? (rptr - FIFO_AW'(1)) : rptr;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= {st_step, st_ez};
        wptr      <= wptr + FIFO_AW'(1);
      end
      if (pop) rptr <= rptr + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + (FIFO_AW + 1)'(1);
        2'b01:   level <= level - (FIFO_AW + 1)'(1);
        default: level <= level;
      endcase
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  // When empty the head selector points at the last popped slot, so the
  // read data holds its previous value.
  assign {rd_step, rd_ez} = mem[head_sel];
  assign rd_valid         = (level != '0);
  assign fifo_level       = level;

endmodule

// File: tb/tb_fdtd_field_probe.sv
// Scoreboard bench for fdtd_field_probe: expected captures are queued as the
// stream is driven and compared as the FIFO is drained.
module tb_fdtd_field_probe;

  localparam int DW    = 32;
  localparam int IW    = 16;
  localparam int SW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          CLK;
  logic          RST_N;
  logic          clken;
  logic          probe_en;
  logic          step_start;
  logic          fld_valid;
  logic [IW-1:0] fld_idx;
  logic [DW-1:0] fld_ez;
  logic [IW-1:0] probe_idx;
  logic [7:0]    decim;
  logic          clr_ovf;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_ez;
  logic [SW-1:0] rd_step;
  logic [AW:0]   fifo_level;
  logic          ovf;

  fdtd_field_probe #(
    .FDTD_DATA_WIDTH(DW), .IDX_WIDTH(IW), .STEP_WIDTH(SW), .FIFO_AW(AW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .clken(clken), .probe_en(probe_en),
    .step_start(step_start), .fld_valid(fld_valid), .fld_idx(fld_idx),
    .fld_ez(fld_ez), .probe_idx(probe_idx), .decim(decim), .clr_ovf(clr_ovf),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ez(rd_ez), .rd_step(rd_step),
    .fifo_level(fifo_level), .ovf(ovf)
  );

  typedef struct {
    logic [SW-1:0] step;
    logic [DW-1:0] ez;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   pops   = 0;
  int   cyc    = 0;
  int   first_rv  = -1;
  int   idx5_cyc  = -1;
  int   m_step = 0;
  bit   m_cap  = 0;
  bit   m_done = 0;
  bit   exp_ovf = 0;
  int   p0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin : monitor
    ent_t e;
    if (rd_valid && first_rv < 0) first_rv = cyc;
    if (RST_N && rd_valid && rd_ready) begin
      if (q.size() == 0) begin
        check("unexpected_pop", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check("rd_step", 64'(rd_step), 64'(e.step));
        check("rd_ez", 64'(rd_ez), 64'(e.ez));
        pops++;
      end
    end
  end

  // One stream beat; the model decides from steps-since-enable whether it is captured.
  task automatic beat(input int idx, input logic [DW-1:0] ez, input bit ss, input bit ce,
                      input bit coincide_pop = 1'b0);
    fld_valid  = 1'b1;
    fld_idx    = IW'(idx);
    fld_ez     = ez;
    step_start = ss;
    clken      = ce;
    if (ss && ce && probe_en) begin
      m_step++;
      m_done = 1'b0;
      m_cap  = ((m_step - 1) % (int'(decim) + 1)) == 0;
    end
    if (ce && probe_en && IW'(idx) == probe_idx && m_cap && !m_done) begin
      m_done = 1'b1;
      if (idx5_cyc < 0) idx5_cyc = cyc;
      if (q.size() < DEPTH || coincide_pop) q.push_back('{step: SW'(m_step), ez: ez});
      else exp_ovf = 1'b1;
    end
    @(posedge CLK); #1;
    fld_valid  = 1'b0;
    step_start = 1'b0;
    clken      = 1'b1;
  endtask

  task automatic run_step(input int first, input int last, input logic [DW-1:0] base);
    for (int i = first; i <= last; i++) beat(i, base + DW'(i * 100), i == first, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic restart(input logic [7:0] d);
    probe_en = 1'b0;
    decim    = d;
    idle(1);
    probe_en = 1'b1;
    m_step = 0; m_cap = 1'b0; m_done = 1'b0;
  endtask

  task automatic drain(input int max);
    rd_ready = 1'b1;
    for (int i = 0; i < max; i++) begin
      if (!rd_valid && q.size() == 0) break;
      idle(1);
    end
    check("drain_queue_empty", 64'(q.size()), 64'd0);
    check("drain_rd_valid", 64'(rd_valid), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; clken = 1'b1; probe_en = 1'b0; step_start = 1'b0;
    fld_valid = 1'b0; fld_idx = '0; fld_ez = '0; probe_idx = IW'(5);
    decim = 8'd0; clr_ovf = 1'b0; rd_ready = 1'b0;
    #12;
    check("reset_outputs", {9'd0, rd_valid, fifo_level, ovf, rd_step, rd_ez}, 64'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    // Basic capture and latency
    restart(8'd0);
    rd_ready = 1'b1; first_rv = -1; idx5_cyc = -1; p0 = pops;
    for (int s = 0; s < 3; s++) run_step(0, 9, '0);
    idle(5);
    check("basic_count", 64'(pops - p0), 64'd3);
    check("basic_latency", 64'(first_rv), 64'(idx5_cyc + 2));

    // Decimation: steps 1, 4, 7
    restart(8'd2); p0 = pops;
    for (int s = 0; s < 7; s++) run_step(3, 7, 32'h1000_0000 + DW'(s));
    idle(5);
    check("decim_count", 64'(pops - p0), 64'd3);

    // Duplicate index within one step
    restart(8'd0); p0 = pops;
    beat(4, 32'd7, 1'b1, 1'b1);
    beat(5, 32'd11, 1'b0, 1'b1);
    beat(5, 32'd22, 1'b0, 1'b1);
    idle(5);
    check("dup_count", 64'(pops - p0), 64'd1);

    // clken low on the probe beat, then step_start coincident with the probe beat
    restart(8'd0); p0 = pops;
    beat(4, 32'd7, 1'b1, 1'b1);
    beat(5, 32'd33, 1'b0, 1'b0);
    beat(6, 32'd44, 1'b0, 1'b1);
    idle(5);
    check("clken_count", 64'(pops - p0), 64'd0);
    run_step(5, 6, 32'h0000_2000);
    idle(5);
    check("coincide_count", 64'(pops - p0), 64'd1);

    // Overflow with rd_ready low; negative Ez checks bit-exact pass-through
    restart(8'd0); rd_ready = 1'b0; exp_ovf = 1'b0;
    for (int s = 1; s <= 17; s++) run_step(4, 6, 32'hF000_0000 + DW'(s));
    idle(4);
    check("ovf_level", 64'(fifo_level), 64'd16);
    check("ovf_flag", 64'(ovf), 64'(exp_ovf));
    check("ovf_rd_valid", 64'(rd_valid), 64'd1);
    check("ovf_head_step", 64'(rd_step), 64'd1);
    clr_ovf = 1'b1; idle(1); clr_ovf = 1'b0;
    check("ovf_cleared", 64'(ovf), 64'd0);

    // Full FIFO: pop on the push cycle lets the push through
    beat(4, 32'h0000_0abc, 1'b1, 1'b1);
    beat(5, 32'h8000_0001, 1'b0, 1'b1, 1'b1);
    rd_ready = 1'b1; idle(1); rd_ready = 1'b0;
    idle(2);
    check("fullpop_level", 64'(fifo_level), 64'd16);
    check("fullpop_ovf", 64'(ovf), 64'd0);
    drain(60);

    // Asynchronous reset mid-stream
    restart(8'd0); rd_ready = 1'b0;
    for (int s = 0; s < 3; s++) run_step(4, 6, 32'h0000_0300);
    idle(3);
    check("prerst_level", 64'(fifo_level), 64'd3);
    fld_valid = 1'b1; fld_idx = IW'(5); step_start = 1'b1; fld_ez = 32'd99;
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    check("rst_async_outputs", {9'd0, rd_valid, fifo_level, ovf, rd_step, rd_ez}, 64'd0);
    q.delete();
    fld_valid = 1'b0; step_start = 1'b0;
    idle(2);
    RST_N = 1'b1;
    idle(3);
    check("postrst_level", 64'(fifo_level), 64'd0);
    check("postrst_rd_valid", 64'(rd_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
